// File: rtl/glay_cu_control_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : glay_cu_control_responder_if
// Purpose  : Descriptor, PE handshake and status bundle for the cluster
//            control responder.
// Revision : 1.0
// ============================================================================
interface glay_cu_control_responder_if #(
  parameter int NUM_GRAPH_PE     = 4,
  parameter int DESCRIPTOR_WIDTH = 512
);
  logic                        descriptor_in_valid;
  logic [DESCRIPTOR_WIDTH-1:0] descriptor_in_payload;
  logic [NUM_GRAPH_PE-1:0]     pe_setup_done_in;
  logic [NUM_GRAPH_PE-1:0]     pe_done_in;
  logic                        cu_setup_out;
  logic                        cu_done_out;
  logic [NUM_GRAPH_PE-1:0]     pe_start_out;
  logic                        descriptor_out_valid;
  logic [DESCRIPTOR_WIDTH-1:0] descriptor_out_payload;
  logic [31:0]                 busy_cycles_out;

  modport master (
    output descriptor_in_valid, descriptor_in_payload, pe_setup_done_in, pe_done_in,
    input  cu_setup_out, cu_done_out, pe_start_out, descriptor_out_valid,
           descriptor_out_payload, busy_cycles_out
  );

  modport slave (
    input  descriptor_in_valid, descriptor_in_payload, pe_setup_done_in, pe_done_in,
    output cu_setup_out, cu_done_out, pe_start_out, descriptor_out_valid,
           descriptor_out_payload, busy_cycles_out
  );
endinterface
`default_nettype wire

// File: rtl/glay_cu_control_responder.sv
`default_nettype none
// ============================================================================
// Module   : glay_cu_control_responder
// Purpose  : Cluster end of the kernel control chain: setup gating, descriptor
//            latch, PE start fan-out, done aggregation and busy profiling.
// Revision : 1.0
// ============================================================================
module glay_cu_control_responder #(
  parameter int NUM_GRAPH_PE     = 4,
  parameter int DESCRIPTOR_WIDTH = 512,
  parameter int SETUP_CYCLES     = 16
) (
  input logic                        ap_clk,
  input logic                        areset,
  glay_cu_control_responder_if.slave cu_if
);
  localparam logic [2:0] c_ST_RESET = 3'd0;
  localparam logic [2:0] c_ST_SETUP = 3'd1;
  localparam logic [2:0] c_ST_IDLE  = 3'd2;
  localparam logic [2:0] c_ST_LATCH = 3'd3;
  localparam logic [2:0] c_ST_START = 3'd4;
  localparam logic [2:0] c_ST_BUSY  = 3'd5;
  localparam logic [2:0] c_ST_DONE  = 3'd6;

  localparam int                     c_SETUP_CNT_W = $clog2(SETUP_CYCLES + 1);
  localparam logic [c_SETUP_CNT_W-1:0] c_SETUP_MAX = c_SETUP_CNT_W'(SETUP_CYCLES);

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_next;
  logic [c_SETUP_CNT_W-1:0]    r_setup_cnt;
  logic [c_SETUP_CNT_W-1:0]    w_setup_cnt_next;
  logic [NUM_GRAPH_PE-1:0]     r_done_mask;
  logic [NUM_GRAPH_PE-1:0]     w_mask_upd;
  logic [31:0]                 r_busy_cnt;
  logic [31:0]                 w_busy_inc;
  logic                        r_cu_setup;
  logic                        r_cu_done;
  logic [NUM_GRAPH_PE-1:0]     r_pe_start;
  logic                        r_desc_valid;
  logic [DESCRIPTOR_WIDTH-1:0] r_desc_payload;
  logic [31:0]                 r_busy_cycles;

  assign w_setup_cnt_next = (r_setup_cnt == c_SETUP_MAX) ? r_setup_cnt
                                                         : r_setup_cnt + c_SETUP_CNT_W'(1);
  assign w_busy_inc       = (r_busy_cnt == 32'hFFFF_FFFF) ? r_busy_cnt : r_busy_cnt + 32'd1;
  assign w_mask_upd       = r_done_mask | cu_if.pe_done_in;

  // Losing descriptor valid mid-run takes priority over completing the run.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_RESET: w_state_next = c_ST_SETUP;
      c_ST_SETUP: if (w_setup_cnt_next == c_SETUP_MAX && (&cu_if.pe_setup_done_in))
                    w_state_next = c_ST_IDLE;
      c_ST_IDLE:  if (cu_if.descriptor_in_valid) w_state_next = c_ST_LATCH;
      c_ST_LATCH: w_state_next = cu_if.descriptor_in_valid ? c_ST_START : c_ST_IDLE;
      c_ST_START: w_state_next = cu_if.descriptor_in_valid ? c_ST_BUSY : c_ST_IDLE;
      c_ST_BUSY: begin
        if (!cu_if.descriptor_in_valid) w_state_next = c_ST_IDLE;
        else if (&w_mask_upd)           w_state_next = c_ST_DONE;
      end
      c_ST_DONE:  if (!cu_if.descriptor_in_valid) w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_RESET;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state        <= c_ST_RESET;
      r_setup_cnt    <= '0;
      r_done_mask    <= '0;
      r_busy_cnt     <= '0;
      r_cu_setup     <= 1'b1;
      r_cu_done      <= 1'b0;
      r_pe_start     <= '0;
      r_desc_valid   <= 1'b0;
      r_desc_payload <= '0;
      r_busy_cycles  <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == c_ST_SETUP) r_setup_cnt <= w_setup_cnt_next;

      if (r_state == c_ST_IDLE && cu_if.descriptor_in_valid) begin
        r_done_mask    <= '0;
        r_desc_payload <= cu_if.descriptor_in_payload;
      end else if (r_state == c_ST_START || r_state == c_ST_BUSY) begin
        r_done_mask <= cu_if.descriptor_in_valid ? w_mask_upd : '0;
      end

      if (r_state == c_ST_START)     r_busy_cnt <= '0;
      else if (r_state == c_ST_BUSY) r_busy_cnt <= w_busy_inc;

      if (r_state == c_ST_BUSY && w_state_next == c_ST_DONE) r_busy_cycles <= w_busy_inc;

      // Outputs follow the state being entered, not the one being left.
      r_cu_setup   <= (w_state_next == c_ST_RESET) || (w_state_next == c_ST_SETUP);
      r_cu_done    <= (w_state_next == c_ST_DONE);
      r_pe_start   <= (w_state_next == c_ST_START) ? {NUM_GRAPH_PE{1'b1}} : '0;
      r_desc_valid <= (w_state_next == c_ST_LATCH) || (w_state_next == c_ST_START) ||
                      (w_state_next == c_ST_BUSY);
    end
  end

  assign cu_if.cu_setup_out           = r_cu_setup;
  assign cu_if.cu_done_out            = r_cu_done;
  assign cu_if.pe_start_out           = r_pe_start;
  assign cu_if.descriptor_out_valid   = r_desc_valid;
  assign cu_if.descriptor_out_payload = r_desc_payload;
  assign cu_if.busy_cycles_out        = r_busy_cycles;
endmodule
`default_nettype wire

// File: tb/tb_glay_cu_control_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_glay_cu_control_responder
// Purpose  : Randomized scoreboard bench for the cluster control responder.
// Revision : 1.0
// ============================================================================
module tb_glay_cu_control_responder;
  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_REL   = 2;
  localparam int K_ABORT = 3;

  typedef struct {
    int           kind;
    int           cyc;
    logic [31:0]  busy;
    logic [511:0] payload;
  } ev_t;

  logic ap_clk;
  logic areset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  ev_t  sb[$];
  int   rp[4];
  int   rd[4];
  logic [31:0] model_busy = 0;

  glay_cu_control_responder_if #(.NUM_GRAPH_PE(4), .DESCRIPTOR_WIDTH(512)) bus ();

  glay_cu_control_responder #(
    .NUM_GRAPH_PE(4), .DESCRIPTOR_WIDTH(512), .SETUP_CYCLES(16)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .cu_if (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int max4();
    int m = 0;
    for (int i = 0; i < 4; i++) if (rp[i] > m) m = rp[i];
    return m;
  endfunction

  task automatic push(input int kind, input int c, input logic [31:0] b, input logic [511:0] pl);
    ev_t e;
    e.kind = kind; e.cyc = c; e.busy = b; e.payload = pl;
    sb.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT shows an observable event.
  logic       prev_done = 1'b0;
  logic       prev_dv = 1'b0;
  logic [3:0] prev_start = 4'h0;
  ev_t        m_e;

  task automatic pop_ev(input string nm, output ev_t e, output bit ok);
    if (sb.size() == 0) begin
      checks++; failures++; ok = 0;
      $display("FAIL %s unexpected event at cycle %0d (no expectation queued)", nm, cyc);
    end else begin
      e = sb.pop_front(); ok = 1;
    end
  endtask

  always @(negedge ap_clk) begin
    bit ok;
    if (mon_en) begin
      if (bus.pe_start_out != 4'h0) begin
        chk("start_width", prev_start, 0);
        pop_ev("start", m_e, ok);
        if (ok) begin
          chk("start_kind", m_e.kind, K_START);
          chk("start_cycle", cyc, m_e.cyc);
          chk("start_value", bus.pe_start_out, 4'hF);
          chk("start_payload", bus.descriptor_out_payload, m_e.payload);
          chk("start_desc_valid", bus.descriptor_out_valid, 1);
        end
      end
      if (bus.cu_done_out && !prev_done) begin
        pop_ev("done", m_e, ok);
        if (ok) begin
          chk("done_kind", m_e.kind, K_DONE);
          chk("done_cycle", cyc, m_e.cyc);
          chk("done_busy_cycles", bus.busy_cycles_out, m_e.busy);
          chk("done_desc_valid", bus.descriptor_out_valid, 0);
        end
      end else if (!bus.cu_done_out && prev_done) begin
        pop_ev("release", m_e, ok);
        if (ok) begin
          chk("release_kind", m_e.kind, K_REL);
          chk("release_cycle", cyc, m_e.cyc);
        end
      end
      if (prev_dv && !bus.descriptor_out_valid && !bus.cu_done_out) begin
        pop_ev("abort", m_e, ok);
        if (ok) begin
          chk("abort_kind", m_e.kind, K_ABORT);
          chk("abort_cycle", cyc, m_e.cyc);
          chk("abort_busy_kept", bus.busy_cycles_out, m_e.busy);
        end
      end
    end
    prev_done  <= bus.cu_done_out;
    prev_dv    <= bus.descriptor_out_valid;
    prev_start <= bus.pe_start_out;
  end

  // One run: cycle 0 is IDLE with valid, 1 LATCH, 2 START (pulse index 0),
  // 2+j is BUSY cycle j. Expected events are derived from the pulse schedule.
  task automatic do_run(input logic [511:0] pl, input int abort_t, input int hold,
                        input int gap, input bit noise);
    int maxp, maxb, base, t_last;
    logic [3:0] pd;
    maxp = max4();
    maxb = (maxp < 1) ? 1 : maxp;
    @(negedge ap_clk);
    base = cyc;
    if (abort_t < 0) begin
      t_last = 3 + maxb + hold;
      push(K_START, base + 2, 0, pl);
      push(K_DONE, base + 3 + maxb, maxb, pl);
      push(K_REL, base + t_last + 1, 0, pl);
      model_busy = maxb;
    end else begin
      t_last = abort_t;
      if (abort_t >= 2) push(K_START, base + 2, 0, pl);
      push(K_ABORT, base + abort_t + 1, model_busy, pl);
    end
    for (int t = 0; t <= t_last; t++) begin
      if (t > 0) @(negedge ap_clk);
      bus.descriptor_in_valid   = (t < t_last);
      bus.descriptor_in_payload = (t == 0) ? pl : rand512();
      pd = 4'h0;
      for (int i = 0; i < 4; i++)
        if (t == 2 + rp[i] || (rd[i] >= 0 && t == 2 + rd[i])) pd[i] = 1'b1;
      if (noise && t < 2) pd = 4'($urandom);
      bus.pe_done_in = pd;
    end
    for (int g = 1; g < gap; g++) begin
      @(negedge ap_clk);
      bus.descriptor_in_valid = 1'b0;
      bus.pe_done_in = 4'h0;
    end
    @(negedge ap_clk);
    bus.pe_done_in = 4'h0;
    bus.descriptor_in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int mp, mb, ab;
    areset = 1'b1;
    bus.descriptor_in_valid   = 1'b0;
    bus.descriptor_in_payload = '0;
    bus.pe_setup_done_in      = 4'hF;
    bus.pe_done_in            = 4'h0;
    repeat (3) @(negedge ap_clk);
    chk("reset_setup", bus.cu_setup_out, 1);
    chk("reset_done", bus.cu_done_out, 0);
    chk("reset_start", bus.pe_start_out, 0);
    chk("reset_desc_valid", bus.descriptor_out_valid, 0);
    chk("reset_payload", bus.descriptor_out_payload, 0);
    chk("reset_busy", bus.busy_cycles_out, 0);
    areset = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge ap_clk);
      chk($sformatf("setup_gate_edge%0d", n), bus.cu_setup_out, (n < 17) ? 1 : 0);
    end
    mon_en = 1;

    rp = '{3, 5, 5, 9};  rd = '{-1, -1, -1, -1};
    do_run(512'hA5, -1, 20, 1, 0);
    rp = '{0, 2, 6, 7};  rd = '{-1, 4, -1, -1};
    do_run(rand512(), -1, 2, 2, 0);
    rp = '{1, 2, 6, 8};  rd = '{-1, -1, -1, -1};
    do_run(rand512(), 6, 0, 3, 0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) rp[i] = int'($urandom_range(0, 10));
      mp = max4();
      mb = (mp < 1) ? 1 : mp;
      for (int i = 0; i < 4; i++)
        rd[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(rp[i], mp)) : -1;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 1 + mb)) : -1;
      do_run(rand512(), ab, int'($urandom_range(0, 5)), int'($urandom_range(1, 3)),
             1'($urandom_range(0, 1)));
    end
    repeat (5) @(negedge ap_clk);
    chk("scoreboard_drain", sb.size(), 0);

    // Asynchronous reset in the middle of a run.
    mon_en = 0;
    bus.descriptor_in_valid   = 1'b1;
    bus.descriptor_in_payload = rand512();
    repeat (5) @(negedge ap_clk);
    chk("pre_reset_busy_valid", bus.descriptor_out_valid, 1);
    @(posedge ap_clk);
    #2 areset = 1'b1;
    #1;
    chk("async_setup", bus.cu_setup_out, 1);
    chk("async_done", bus.cu_done_out, 0);
    chk("async_start", bus.pe_start_out, 0);
    chk("async_desc_valid", bus.descriptor_out_valid, 0);
    chk("async_payload", bus.descriptor_out_payload, 0);
    chk("async_busy", bus.busy_cycles_out, 0);
    bus.descriptor_in_valid = 1'b0;
    bus.pe_setup_done_in    = 4'b1011;
    @(negedge ap_clk);
    areset = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      @(negedge ap_clk);
      chk($sformatf("setup_wait_edge%0d", n), bus.cu_setup_out, (n < 31) ? 1 : 0);
      if (n == 30) bus.pe_setup_done_in = 4'hF;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
